// File: rtl/ctrlsoc_pkg.sv
// Shared definitions for the ctrlsoc flash read-port arbiter: state encoding
// and the default flash byte-address width.
package ctrlsoc_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 24;
  localparam int unsigned BURST_CNT_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2,
    ST_GAP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ctrlsoc_flasharb.sv
// Two-requester arbiter for the single shared flash read port: CPU (m0) and
// the mlaccel weight-loader DMA (m1), with a burst limit applied under contention.
module ctrlsoc_flasharb
  import ctrlsoc_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_valid,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_ready,
  output logic [31:0]       m0_rdata,
  input  logic              m1_valid,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic              m1_ready,
  output logic [31:0]       m1_rdata,
  output logic              s_valid,
  output logic [ADDR_W-1:0] s_addr,
  input  logic              s_ready,
  input  logic [31:0]       s_rdata,
  output logic [1:0]        grant
);

  arb_state_t             state;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic                   last_grant;

  logic              own_valid;
  logic              other_valid;
  logic [ADDR_W-1:0] own_addr;
  logic              at_limit;

  always_comb begin
    own_valid   = 1'b0;
    other_valid = 1'b0;
    own_addr    = '0;
    case (state)
      ST_OWN0: begin
        own_valid   = m0_valid;
        other_valid = m1_valid;
        own_addr    = m0_addr;
      end
      ST_OWN1: begin
        own_valid   = m1_valid;
        other_valid = m0_valid;
        own_addr    = m1_addr;
      end
      default: ;
    endcase
  end

  // True when the word completing this cycle brings the burst to MAX_BURST
  // (also true once the counter has saturated during an uncontended stream).
  assign at_limit = burst_cnt >= BURST_CNT_W'(MAX_BURST - 1);

  always_comb begin
    s_valid  = 1'b0;
    s_addr   = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    grant    = 2'b00;
    if (own_valid && !s_ready) begin
      s_valid = 1'b1;
      s_addr  = own_addr;
    end
    case (state)
      ST_OWN0: begin
        m0_ready = s_ready;
        m0_rdata = s_rdata;
        grant    = 2'b01;
      end
      ST_OWN1: begin
        m1_ready = s_ready;
        m1_rdata = s_rdata;
        grant    = 2'b10;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      burst_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          burst_cnt <= '0;
          if (m0_valid && (!m1_valid || last_grant)) begin
            state <= ST_OWN0;
          end else if (m1_valid) begin
            state <= ST_OWN1;
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (s_ready && burst_cnt != BURST_CNT_W'(MAX_BURST)) begin
            burst_cnt <= burst_cnt + 1'b1;
          end
          if (!own_valid || (s_ready && other_valid && at_limit)) begin
            state      <= ST_GAP;
            last_grant <= (state == ST_OWN1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrlsoc_flasharb.sv
// Randomized bench for ctrlsoc_flasharb: requester and flash-latency models drive
// the DUT; an ownership-level reference model predicts every output each cycle.
module tb_ctrlsoc_flasharb;

  localparam int unsigned AW = 24;
  localparam int          MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_valid, m1_valid;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          s_valid;
  logic [AW-1:0] s_addr;
  logic          s_ready;
  logic [31:0]   s_rdata;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  ctrlsoc_flasharb #(.MAX_BURST(MB), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_addr(s_addr), .s_ready(s_ready), .s_rdata(s_rdata),
    .grant(grant)
  );

  int total = 0;
  int bad   = 0;

  // requester and flash environment
  int            rem[2];
  logic [AW-1:0] raddr[2];
  bit            en[2];
  bit            en0_after_m1;
  int unsigned   lat_min, lat_max;
  bit            sl_pend;
  int            sl_cnt;
  logic [AW-1:0] sl_addr;

  // reference model: owner -1 = nobody, gap = one dead cycle after a tenure
  int own, last, words;
  bit gap;

  bit            have_prev, p_rst, p_sr, p_sv;
  bit            p_v[2], p_rdy[2];
  logic [AW-1:0] p_saddr;

  logic [AW+68:0] exp_obs, act_obs;

  function automatic logic [31:0] mem(input logic [AW-1:0] a);
    return {8'hC3, a} ^ {a[7:0], 24'h5A5A5A};
  endfunction

  function automatic bit all_done();
    return rem[0] == 0 && rem[1] == 0 && own < 0 && !gap && !sl_pend;
  endfunction

  task automatic step(input bit rst);
    logic [1:0]    eg;
    logic          esv, er0, er1, vo;
    logic [AW-1:0] esa;
    logic [31:0]   ed0, ed1;
    if (have_prev) begin
      if (p_rst) begin
        own = -1; gap = 0; last = 1; words = 0;
      end else if (gap) begin
        gap = 0;
      end else if (own < 0) begin
        words = 0;
        if (p_v[0] && p_v[1]) own = 1 - last;
        else if (p_v[0])      own = 0;
        else if (p_v[1])      own = 1;
      end else begin
        if (p_sr) words = (words + 1 > MB) ? MB : words + 1;
        if (!p_v[own] || (p_sr && p_v[1-own] && words == MB)) begin
          last = own; own = -1; gap = 1;
        end
      end
      for (int n = 0; n < 2; n++)
        if (p_rdy[n] && rem[n] > 0) begin
          rem[n]--;
          raddr[n] = raddr[n] + AW'(4);
        end
      if (p_sr) sl_pend = 0;
      else if (sl_pend) sl_cnt--;
      else if (p_sv) begin
        sl_pend = 1;
        sl_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
        sl_addr = p_saddr;
      end
    end
    @(negedge clk);
    if (en0_after_m1 && rem[1] == 0) en[0] = 1;
    reset    = rst;
    m0_valid = en[0] && rem[0] > 0;
    m1_valid = en[1] && rem[1] > 0;
    m0_addr  = raddr[0];
    m1_addr  = raddr[1];
    s_ready  = sl_pend && sl_cnt == 0;
    s_rdata  = s_ready ? mem(sl_addr) : $urandom;
    #1;
    eg = 2'b00; esv = 0; esa = '0; er0 = 0; er1 = 0; ed0 = '0; ed1 = '0;
    if (own >= 0) begin
      vo = (own == 0) ? m0_valid : m1_valid;
      eg = (own == 0) ? 2'b01 : 2'b10;
      if (vo && !s_ready) begin
        esv = 1;
        esa = (own == 0) ? m0_addr : m1_addr;
      end
      if (own == 0) begin er0 = s_ready; ed0 = s_rdata; end
      else          begin er1 = s_ready; ed1 = s_rdata; end
    end
    exp_obs = {eg, esv, esa, er0, er1, ed0, ed1};
    act_obs = {grant, s_valid, s_addr, m0_ready, m1_ready, m0_rdata, m1_rdata};
    p_rst = rst; p_v[0] = m0_valid; p_v[1] = m1_valid; p_sr = s_ready;
    p_sv = s_valid; p_saddr = s_addr; p_rdy[0] = m0_ready; p_rdy[1] = m1_ready;
    have_prev = 1;
  endtask

  task automatic do_reset();
    en[0] = 0; en[1] = 0; en0_after_m1 = 0; rem[0] = 0; rem[1] = 0;
    lat_min = 1; lat_max = 1;
    step(1);
    step(1);
  endtask

  task automatic test_reset();
    en[0] = 0; en[1] = 0; rem[0] = 0; rem[1] = 0; lat_min = 1; lat_max = 1;
    step(1);  // DUT state is unknown before this first edge
    step(1);
    total++;
    if (act_obs !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", act_obs);
    end
    rem[0] = 2; rem[1] = 2;  // valids high while still in reset
    en[0] = 1; en[1] = 1;
    step(1);
    total++;
    if (act_obs !== '0) begin
      bad++; $display("FAIL reset_hold got=%h want=0", act_obs);
    end
    do_reset();
  endtask

  task automatic test_single();
    int  n0 = 0, n1 = 0;
    bit  seen01 = 0;
    do_reset();
    lat_min = 17; lat_max = 17;
    rem[0] = 4; raddr[0] = 24'h100000; en[0] = 1;
    for (int c = 0; c < 200 && !all_done(); c++) begin
      step(0);
      total++;
      if (act_obs !== exp_obs) begin
        bad++; $display("FAIL single_cycle c=%0d got=%h want=%h", c, act_obs, exp_obs);
      end
      if (m0_ready) begin
        n0++; total++;
        if (m0_rdata !== mem(raddr[0])) begin
          bad++; $display("FAIL single_data got=%h want=%h", m0_rdata, mem(raddr[0]));
        end
      end
      if (m1_ready) n1++;
      if (grant == 2'b01) seen01 = 1;
    end
    total++; if (!all_done()) begin bad++; $display("FAIL single_timeout got=busy want=done"); end
    total++; if (n0 != 4)     begin bad++; $display("FAIL single_m0_words got=%0d want=4", n0); end
    total++; if (n1 != 0)     begin bad++; $display("FAIL single_m1_ready got=%0d want=0", n1); end
    total++; if (!seen01)     begin bad++; $display("FAIL single_grant got=never want=01"); end
  endtask

  task automatic test_both();
    logic [1:0] first_g = 2'b00;
    bit  in0 = 0;
    int  zrun = 0, zgap = -1, n0 = 0, n1 = 0;
    do_reset();
    lat_min = 1; lat_max = 3;
    rem[0] = 3; raddr[0] = 24'h000200; en[0] = 1;
    rem[1] = 3; raddr[1] = 24'h800000; en[1] = 1;
    for (int c = 0; c < 100 && !all_done(); c++) begin
      step(0);
      total++;
      if (act_obs !== exp_obs) begin
        bad++; $display("FAIL both_cycle c=%0d got=%h want=%h", c, act_obs, exp_obs);
      end
      if (first_g == 2'b00 && grant != 2'b00) first_g = grant;
      if (grant == 2'b01) begin in0 = 1; zrun = 0; end
      else if (grant == 2'b00 && in0) zrun++;
      else if (grant == 2'b10 && in0 && zgap < 0) zgap = zrun;
      if (m0_ready) n0++;
      if (m1_ready) n1++;
    end
    total++; if (!all_done())      begin bad++; $display("FAIL both_timeout got=busy want=done"); end
    total++; if (first_g !== 2'b01) begin bad++; $display("FAIL both_first_grant got=%b want=01", first_g); end
    total++; if (zgap != 2)        begin bad++; $display("FAIL both_gap_cycles got=%0d want=2", zgap); end
    total++; if (n0 != 3 || n1 != 3) begin bad++; $display("FAIL both_words got=%0d/%0d want=3/3", n0, n1); end
  endtask

  task automatic test_burst();
    int n0b = 0, n0 = 0, n1 = 0;
    bit m1_started = 0;
    do_reset();
    lat_min = 2; lat_max = 2;
    rem[0] = 20; raddr[0] = 24'h010000; en[0] = 1;
    rem[1] = 3;  raddr[1] = 24'h020000;
    for (int c = 0; c < 300 && !all_done(); c++) begin
      if (c == 10) en[1] = 1;
      step(0);
      total++;
      if (act_obs !== exp_obs) begin
        bad++; $display("FAIL burst_cycle c=%0d got=%h want=%h", c, act_obs, exp_obs);
      end
      if (m1_ready) m1_started = 1;
      if (m0_ready) begin n0++; if (!m1_started) n0b++; end
      if (m1_ready) n1++;
    end
    total++; if (!all_done()) begin bad++; $display("FAIL burst_timeout got=busy want=done"); end
    total++; if (n0b != MB)   begin bad++; $display("FAIL burst_limit got=%0d want=%0d", n0b, MB); end
    total++; if (n0 != 20 || n1 != 3) begin bad++; $display("FAIL burst_words got=%0d/%0d want=20/3", n0, n1); end
  endtask

  task automatic test_solo_stream();
    int  n1 = 0, off = 0;
    bit  started = 0;
    do_reset();
    lat_min = 1; lat_max = 4;
    rem[1] = 40; raddr[1] = 24'h400000; en[1] = 1;
    for (int c = 0; c < 260 && !all_done(); c++) begin
      step(0);
      total++;
      if (act_obs !== exp_obs) begin
        bad++; $display("FAIL solo_cycle c=%0d got=%h want=%h", c, act_obs, exp_obs);
      end
      if (grant == 2'b10) started = 1;
      if (started && rem[1] > 0 && grant != 2'b10) off++;
      if (m1_ready) begin
        n1++; total++;
        if (m1_rdata !== mem(raddr[1])) begin
          bad++; $display("FAIL solo_data got=%h want=%h", m1_rdata, mem(raddr[1]));
        end
      end
    end
    total++; if (!all_done()) begin bad++; $display("FAIL solo_timeout got=busy want=done"); end
    total++; if (off != 0)    begin bad++; $display("FAIL solo_grant_lost got=%0d want=0", off); end
    total++; if (n1 != 40)    begin bad++; $display("FAIL solo_words got=%0d want=40", n1); end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    do_reset();
    lat_min = 2; lat_max = 2;
    rem[0] = 5; raddr[0] = 24'h000040; en[0] = 1;
    for (int c = 0; c < 10 && !found; c++) begin
      step(0);
      total++;
      if (act_obs !== exp_obs) begin
        bad++; $display("FAIL rstmid_cycle c=%0d got=%h want=%h", c, act_obs, exp_obs);
      end
      if (s_valid) found = 1;
    end
    total++; if (!found) begin bad++; $display("FAIL rstmid_issue got=none want=s_valid"); end
    step(1);  // reset while the word is outstanding; flash answers next cycle
    total++; if (s_valid !== 1'b1) begin bad++; $display("FAIL rstmid_pending got=%b want=1", s_valid); end
    en[0] = 0;
    step(0);
    total++;
    if (act_obs !== '0) begin
      bad++; $display("FAIL rstmid_outputs got=%h want=0", act_obs);
    end
    step(0);
    total++;
    if (act_obs !== exp_obs) begin
      bad++; $display("FAIL rstmid_after got=%h want=%h", act_obs, exp_obs);
    end
  endtask

  task automatic test_handover();
    logic [1:0]    gq[$];
    logic          svq[$];
    logic [AW-1:0] saq[$];
    int            t = -1;
    do_reset();
    lat_min = 1; lat_max = 3;
    rem[1] = 3; raddr[1] = 24'h300000; en[1] = 1;
    rem[0] = 2; raddr[0] = 24'h000800; en0_after_m1 = 1;
    for (int c = 0; c < 100 && !all_done(); c++) begin
      step(0);
      total++;
      if (act_obs !== exp_obs) begin
        bad++; $display("FAIL hand_cycle c=%0d got=%h want=%h", c, act_obs, exp_obs);
      end
      gq.push_back(grant); svq.push_back(s_valid); saq.push_back(s_addr);
      if (m1_ready) t = gq.size() - 1;
    end
    total++;
    if (t < 0 || t + 4 >= gq.size()) begin
      bad++; $display("FAIL hand_trace got=%0d want=%0d", gq.size(), t + 5);
    end else begin
      if (gq[t+1] !== 2'b10) begin bad++; $display("FAIL hand_tail got=%b want=10", gq[t+1]); end
      total++;
      if (gq[t+2] !== 2'b00 || svq[t+2] !== 1'b0 || saq[t+2] !== '0) begin
        bad++; $display("FAIL hand_gap got=%b/%b/%h want=00/0/0", gq[t+2], svq[t+2], saq[t+2]);
      end
      total++;
      if (gq[t+4] !== 2'b01) begin bad++; $display("FAIL hand_own0 got=%b want=01", gq[t+4]); end
    end
  endtask

  task automatic test_random();
    int s0, s1;
    for (int r = 0; r < 8; r++) begin
      do_reset();
      lat_min = 1; lat_max = $urandom_range(5, 1);
      rem[0] = $urandom_range(10, 0); raddr[0] = AW'({$urandom_range(16'hFFFF, 0), 2'b00});
      rem[1] = $urandom_range(10, 0); raddr[1] = AW'({$urandom_range(16'hFFFF, 0), 2'b00});
      s0 = $urandom_range(15, 0); s1 = $urandom_range(15, 0);
      for (int c = 0; c < 400 && !all_done(); c++) begin
        if (c == s0) en[0] = 1;
        if (c == s1) en[1] = 1;
        step(0);
        total++;
        if (act_obs !== exp_obs) begin
          bad++; $display("FAIL rand_cycle r=%0d c=%0d got=%h want=%h", r, c, act_obs, exp_obs);
        end
        if (m0_ready && m0_rdata !== mem(raddr[0])) begin
          bad++; $display("FAIL rand_m0_data got=%h want=%h", m0_rdata, mem(raddr[0]));
        end
        if (m1_ready && m1_rdata !== mem(raddr[1])) begin
          bad++; $display("FAIL rand_m1_data got=%h want=%h", m1_rdata, mem(raddr[1]));
        end
      end
      total++; if (!all_done()) begin bad++; $display("FAIL rand_timeout r=%0d got=busy want=done", r); end
    end
  endtask

  initial begin
    reset = 1'b1; m0_valid = 0; m1_valid = 0; m0_addr = '0; m1_addr = '0;
    s_ready = 0; s_rdata = '0;
    own = -1; gap = 0; last = 1; words = 0;
    sl_pend = 0; sl_cnt = 0; sl_addr = '0; have_prev = 0;
    raddr[0] = '0; raddr[1] = '0;
    test_reset();
    test_single();
    test_both();
    test_burst();
    test_solo_stream();
    test_reset_mid();
    test_handover();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
